node_span_scheduler: RTL and testbench

NODE_SPAN_SCHEDULER -- requirements
Module: node_span_scheduler

---
 rtl/node_span_scheduler_if.sv | 29 ++
 rtl/node_span_scheduler.sv | 169 ++++++++++++++++
 tb/tb_node_span_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_span_scheduler_if.sv
// Rope-node scheduler bus: node positions, video timing in,
// per-line span status and pixel hit out.
interface node_span_scheduler_if #(
   parameter int NODES = 20
);
   logic [NODES*10-1:0] nodes_x;
   logic [NODES*10-1:0] nodes_y;
   logic                frame_start;
   logic                line_start;
   logic [9:0]          next_y;
   logic                video_on;
   logic [9:0]          pix_x;
   logic                hit;
   logic                busy;
   logic [2:0]          span_count;
   logic                overflow;

   modport master (
      output nodes_x, nodes_y, frame_start, line_start,
      output next_y, video_on, pix_x,
      input  hit, busy, span_count, overflow
   );

   modport slave (
      input  nodes_x, nodes_y, frame_start, line_start,
      input  next_y, video_on, pix_x,
      output hit, busy, span_count, overflow
   );
endinterface

// File: rtl/node_span_scheduler.sv
// Per-scanline span builder for rope-node circles: scans all nodes
// during hblank, then tests each pixel against the stored spans.
module node_span_scheduler #(
   parameter int NODES     = 20,
   parameter int RADIUS    = 10,
   parameter int MAX_SPANS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   node_span_scheduler_if.slave   bus
);

   localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0]    MS   = 3'(MAX_SPANS);
   localparam logic [IW-1:0] LAST = IW'(NODES - 1);
   localparam logic [10:0]   RAD  = 11'(RADIUS);

   logic [1:0]    r_state;
   logic [IW-1:0] r_idx;
   logic [9:0]    r_line_y;
   logic          r_pending;
   logic [2:0]    r_cnt;
   logic          r_ovf;
   logic          r_hit;
   logic [9:0]    r_sx [NODES];
   logic [9:0]    r_sy [NODES];
   logic [9:0]    r_lo [MAX_SPANS];
   logic [9:0]    r_hi [MAX_SPANS];

   logic [9:0]  w_sx;
   logic [9:0]  w_sy;
   logic [10:0] w_dy;
   logic        w_in;
   logic [9:0]  w_hw;
   logic [9:0]  w_lo;
   logic [10:0] w_sum;
   logic [9:0]  w_hi;
   logic        w_done;
   logic        w_cap;
   logic        w_match;

   // floor(sqrt(100 - dy^2)) for a radius-10 circle
   function automatic logic [9:0] f_hw(input logic [3:0] dy);
      case (dy)
         4'd0:    f_hw = 10'd10;
         4'd1:    f_hw = 10'd9;
         4'd2:    f_hw = 10'd9;
         4'd3:    f_hw = 10'd9;
         4'd4:    f_hw = 10'd9;
         4'd5:    f_hw = 10'd8;
         4'd6:    f_hw = 10'd8;
         4'd7:    f_hw = 10'd7;
         4'd8:    f_hw = 10'd6;
         4'd9:    f_hw = 10'd4;
         default: f_hw = 10'd0;
      endcase
   endfunction

   assign w_sx = r_sx[r_idx];
   assign w_sy = r_sy[r_idx];

   always_comb begin
      w_dy = 11'd0;
      if (w_sy >= r_line_y)
         w_dy = {1'b0, w_sy} - {1'b0, r_line_y};
      else
         w_dy = {1'b0, r_line_y} - {1'b0, w_sy};
   end

   assign w_in  = (w_dy <= RAD);
   assign w_hw  = f_hw(w_dy[3:0]);
   assign w_lo  = (w_sx < w_hw) ? 10'd0 : (w_sx - w_hw);
   assign w_sum = {1'b0, w_sx} + {1'b0, w_hw};
   assign w_hi  = w_sum[10] ? 10'h3FF : w_sum[9:0];

   assign w_done = (r_state == ST_SCAN) && (r_idx == LAST)
                   && !bus.line_start;
   assign w_cap  = (bus.frame_start && (r_state != ST_SCAN))
                   || (w_done && (r_pending || bus.frame_start));

   // Scan sequencing and span buffer fill
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_line_y <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         for (int k = 0; k < MAX_SPANS; k++) begin
            r_lo[k] <= '0;
            r_hi[k] <= '0;
         end
      end else if (bus.line_start) begin
         r_state  <= ST_SCAN;
         r_idx    <= '0;
         r_line_y <= bus.next_y;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
      end else if (r_state == ST_SCAN) begin
         if (w_in) begin
            if (r_cnt < MS) begin
               for (int k = 0; k < MAX_SPANS; k++) begin
                  if (3'(k) == r_cnt) begin
                     r_lo[k] <= w_lo;
                     r_hi[k] <= w_hi;
                  end
               end
               r_cnt <= r_cnt + 3'd1;
            end else begin
               r_ovf <= 1'b1;
            end
         end
         if (r_idx == LAST) begin
            r_state <= ST_DONE;
            r_idx   <= '0;
         end else begin
            r_idx <= r_idx + IW'(1);
         end
      end
   end

   // A frame_start mid-scan defers the capture to the end of the scan
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
         for (int i = 0; i < NODES; i++) begin
            r_sx[i] <= '0;
            r_sy[i] <= '0;
         end
      end else begin
         if (w_cap) begin
            r_pending <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
               r_sx[i] <= bus.nodes_x[i*10 +: 10];
               r_sy[i] <= bus.nodes_y[i*10 +: 10];
            end
         end else if (bus.frame_start && (r_state == ST_SCAN)) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      w_match = 1'b0;
      for (int k = 0; k < MAX_SPANS; k++) begin
         if ((3'(k) < r_cnt) && (bus.pix_x >= r_lo[k])
             && (bus.pix_x <= r_hi[k]))
            w_match = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_hit <= 1'b0;
      else
         r_hit <= bus.video_on && (r_state == ST_DONE) && w_match;
   end

   assign bus.hit        = r_hit;
   assign bus.busy       = (r_state == ST_SCAN);
   assign bus.span_count = r_cnt;
   assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_node_span_scheduler.sv
// Randomised and directed bench for node_span_scheduler against a
// circle-geometry reference model.
module tb_node_span_scheduler;

   localparam int NODES = 20;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   int mx [NODES];
   int my [NODES];
   int sx [NODES];
   int sy [NODES];
   int elo [$];
   int ehi [$];
   int ecnt;
   bit eovf;

   node_span_scheduler_if #(.NODES(NODES)) bus ();

   node_span_scheduler #(
      .NODES(NODES), .RADIUS(10), .MAX_SPANS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int hw(input int dy);
      for (int h = 10; h >= 0; h--)
         if (h * h + dy * dy <= 100) return h;
      return 0;
   endfunction

   task automatic model_line(input int ly);
      int dy, h, lo, hi;
      elo.delete();
      ehi.delete();
      ecnt = 0;
      eovf = 0;
      for (int i = 0; i < NODES; i++) begin
         dy = (sy[i] > ly) ? sy[i] - ly : ly - sy[i];
         if (dy <= 10) begin
            if (ecnt < 4) begin
               h  = hw(dy);
               lo = sx[i] - h;
               hi = sx[i] + h;
               elo.push_back(lo < 0 ? 0 : lo);
               ehi.push_back(hi > 1023 ? 1023 : hi);
               ecnt++;
            end else begin
               eovf = 1;
            end
         end
      end
   endtask

   function automatic bit exp_hit(input int px);
      foreach (elo[k])
         if (px >= elo[k] && px <= ehi[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_nodes;
      for (int i = 0; i < NODES; i++) begin
         bus.nodes_x[i*10 +: 10] = 10'(mx[i]);
         bus.nodes_y[i*10 +: 10] = 10'(my[i]);
      end
   endtask

   task automatic park_all;
      for (int i = 0; i < NODES; i++) begin
         mx[i] = 0;
         my[i] = 600;
      end
   endtask

   task automatic capture;
      drive_nodes();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      sx = mx;
      sy = my;
   endtask

   task automatic start_line(input int y);
      bus.next_y     = 10'(y);
      bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
      model_line(y);
   endtask

   task automatic finish_scan;
      repeat (NODES) tick();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #3;
      n_tests++;
      if ({bus.busy, bus.hit, bus.overflow} !== 3'b000
          || bus.span_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state busy=%b hit=%b ovf=%b cnt=%0d exp 0",
                  bus.busy, bus.hit, bus.overflow, bus.span_count);
      end
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < NODES; i++) begin
         sx[i] = 0;
         sy[i] = 0;
      end
   endtask

   task automatic test_basic;
      park_all();
      mx[0] = 100;
      my[0] = 50;
      capture();
      bus.video_on = 1'b1;
      bus.pix_x    = 10'd100;
      start_line(50);
      for (int i = 0; i < NODES; i++) begin
         n_tests++;
         if (bus.busy !== 1'b1 || (i > 0 && bus.hit !== 1'b0)) begin
            n_fail++;
            $display("FAIL basic_scan cyc=%0d busy=%b hit=%b exp 1/0",
                     i, bus.busy, bus.hit);
         end
         tick();
      end
      n_tests++;
      if (bus.busy !== 1'b0 || bus.span_count !== 3'(ecnt)) begin
         n_fail++;
         $display("FAIL basic_done busy=%b cnt=%0d exp 0/%0d",
                  bus.busy, bus.span_count, ecnt);
      end
      for (int px = 85; px <= 115; px++) begin
         bus.pix_x = 10'(px);
         tick();
         n_tests++;
         if (bus.hit !== exp_hit(px)) begin
            n_fail++;
            $display("FAIL basic_hit px=%0d got %b exp %b",
                     px, bus.hit, exp_hit(px));
         end
      end
   endtask

   task automatic test_dy_edges;
      int ys [2] = '{59, 61};
      for (int t = 0; t < 2; t++) begin
         start_line(ys[t]);
         finish_scan();
         n_tests++;
         if (bus.span_count !== 3'(ecnt)) begin
            n_fail++;
            $display("FAIL dy_cnt y=%0d got %0d exp %0d",
                     ys[t], bus.span_count, ecnt);
         end
         for (int px = 88; px <= 112; px++) begin
            bus.pix_x = 10'(px);
            tick();
            n_tests++;
            if (bus.hit !== exp_hit(px)) begin
               n_fail++;
               $display("FAIL dy_hit y=%0d px=%0d got %b exp %b",
                        ys[t], px, bus.hit, exp_hit(px));
            end
         end
      end
   endtask

   task automatic test_saturate;
      int pxs [$];
      park_all();
      mx[0] = 3;
      my[0] = 50;
      mx[1] = 1020;
      my[1] = 50;
      capture();
      start_line(50);
      finish_scan();
      n_tests++;
      if (bus.span_count !== 3'(ecnt)) begin
         n_fail++;
         $display("FAIL sat_cnt got %0d exp %0d", bus.span_count, ecnt);
      end
      for (int p = 0; p <= 16; p++) pxs.push_back(p);
      for (int p = 1005; p <= 1023; p++) pxs.push_back(p);
      foreach (pxs[j]) begin
         bus.pix_x = 10'(pxs[j]);
         tick();
         n_tests++;
         if (bus.hit !== exp_hit(pxs[j])) begin
            n_fail++;
            $display("FAIL sat_hit px=%0d got %b exp %b",
                     pxs[j], bus.hit, exp_hit(pxs[j]));
         end
      end
   endtask

   task automatic test_overflow;
      park_all();
      for (int i = 0; i < 6; i++) begin
         mx[i] = 60 + i * 100;
         my[i] = 50;
      end
      capture();
      start_line(50);
      finish_scan();
      n_tests++;
      if (bus.span_count !== 3'(ecnt) || bus.overflow !== eovf) begin
         n_fail++;
         $display("FAIL ovf_state cnt=%0d ovf=%b exp %0d/%b",
                  bus.span_count, bus.overflow, ecnt, eovf);
      end
      for (int i = 0; i < 6; i++) begin
         bus.pix_x = 10'(mx[i]);
         tick();
         n_tests++;
         if (bus.hit !== exp_hit(mx[i])) begin
            n_fail++;
            $display("FAIL ovf_hit node=%0d got %b exp %b",
                     i, bus.hit, exp_hit(mx[i]));
         end
      end
   endtask

   task automatic test_restart;
      int pxs [5] = '{500, 689, 690, 700, 710};
      start_line(50);
      repeat (9) tick();
      n_tests++;
      if (bus.overflow !== 1'b1 || bus.span_count !== 3'd4) begin
         n_fail++;
         $display("FAIL restart_mid ovf=%b cnt=%0d exp 1/4",
                  bus.overflow, bus.span_count);
      end
      start_line(50);
      n_tests++;
      if (bus.overflow !== 1'b0 || bus.span_count !== 3'd0
          || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_clr ovf=%b cnt=%0d busy=%b exp 0/0/1",
                  bus.overflow, bus.span_count, bus.busy);
      end
      for (int i = 0; i < NODES; i++) begin
         n_tests++;
         if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_busy cyc=%0d got %b exp 1", i, bus.busy);
         end
         if (i == 3) begin
            park_all();
            mx[7] = 500;
            my[7] = 50;
            drive_nodes();
            bus.frame_start = 1'b1;
         end
         if (i == 10) begin
            park_all();
            mx[7] = 700;
            my[7] = 50;
            drive_nodes();
         end
         tick();
         bus.frame_start = 1'b0;
      end
      n_tests++;
      if (bus.busy !== 1'b0 || bus.span_count !== 3'(ecnt)
          || bus.overflow !== eovf) begin
         n_fail++;
         $display("FAIL restart_done busy=%b cnt=%0d ovf=%b exp 0/%0d/%b",
                  bus.busy, bus.span_count, bus.overflow, ecnt, eovf);
      end
      sx = mx;
      sy = my;
      start_line(50);
      finish_scan();
      foreach (pxs[j]) begin
         bus.pix_x = 10'(pxs[j]);
         tick();
         n_tests++;
         if (bus.hit !== exp_hit(pxs[j])) begin
            n_fail++;
            $display("FAIL pend_cap px=%0d got %b exp %b",
                     pxs[j], bus.hit, exp_hit(pxs[j]));
         end
      end
   endtask

   task automatic test_random;
      int px;
      bit vo;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < NODES; i++) begin
            mx[i] = int'($urandom_range(0, 1023));
            my[i] = int'($urandom_range(0, 120));
         end
         capture();
         start_line(int'($urandom_range(0, 100)));
         finish_scan();
         n_tests++;
         if (bus.span_count !== 3'(ecnt) || bus.overflow !== eovf) begin
            n_fail++;
            $display("FAIL rand_state it=%0d cnt=%0d ovf=%b exp %0d/%b",
                     it, bus.span_count, bus.overflow, ecnt, eovf);
         end
         for (int j = 0; j < 16; j++) begin
            if (ecnt > 0 && j < 12) begin
               px = (j % 2 == 0) ? elo[(j/4) % ecnt] : ehi[(j/4) % ecnt];
               px = px + ((j % 4 < 2) ? 0 : ((j % 2 == 0) ? -1 : 1));
               if (px < 0) px = 0;
               if (px > 1023) px = 1023;
            end else begin
               px = int'($urandom_range(0, 1023));
            end
            vo = ($urandom_range(0, 3) != 0);
            bus.pix_x    = 10'(px);
            bus.video_on = vo;
            tick();
            n_tests++;
            if (bus.hit !== (vo && exp_hit(px))) begin
               n_fail++;
               $display("FAIL rand_hit it=%0d px=%0d vo=%b got %b exp %b",
                        it, px, vo, bus.hit, vo && exp_hit(px));
            end
         end
      end
      bus.video_on = 1'b1;
   endtask

   task automatic test_async_reset;
      bit pat [31];
      start_line(int'($urandom_range(0, 100)));
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({bus.busy, bus.hit, bus.overflow} !== 3'b000
          || bus.span_count !== 3'd0) begin
         n_fail++;
         $display("FAIL async_rst busy=%b hit=%b ovf=%b cnt=%0d exp 0",
                  bus.busy, bus.hit, bus.overflow, bus.span_count);
      end
      tick();
      reset = 1'b1;
      park_all();
      mx[0] = 300;
      my[0] = 120;
      capture();
      start_line(120);
      finish_scan();
      for (int px = 285; px <= 315; px++) begin
         bus.pix_x = 10'(px);
         tick();
         pat[px-285] = bus.hit;
         n_tests++;
         if (bus.hit !== exp_hit(px)) begin
            n_fail++;
            $display("FAIL hold_ref px=%0d got %b exp %b",
                     px, bus.hit, exp_hit(px));
         end
      end
      for (int i = 0; i < NODES; i++) begin
         mx[i] = int'($urandom_range(0, 1023));
         my[i] = 120;
      end
      drive_nodes();
      start_line(120);
      finish_scan();
      for (int px = 285; px <= 315; px++) begin
         bus.pix_x = 10'(px);
         tick();
         n_tests++;
         if (bus.hit !== exp_hit(px) || bus.hit !== pat[px-285]) begin
            n_fail++;
            $display("FAIL hold_nocap px=%0d got %b exp %b",
                     px, bus.hit, exp_hit(px));
         end
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      bus.nodes_x      = '0;
      bus.nodes_y      = '0;
      bus.frame_start  = 1'b0;
      bus.line_start   = 1'b0;
      bus.next_y       = '0;
      bus.video_on     = 1'b0;
      bus.pix_x        = '0;
      test_reset();
      test_basic();
      test_dy_edges();
      test_saturate();
      test_overflow();
      test_restart();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
